mux_arb_nway: RTL and testbench

- Parametrised successor to the fixed 8-way 16-bit selector.
- Registered N-way, W-bit channel multiplexer with per-channel valid/ready handshakes and a one-entry output register.
- Two selection modes:
  - Round-robin arbitration across all requesting channels.
  - Forced selection from an external select code, as in the plain combinational mux.
- Feeds shared datapath resources (memory write port, ALU operand bus) from several producers.

---
 rtl/mux_arb_nway_if.sv | 28 ++
 rtl/mux_arb_nway.sv | 91 +++++++++
 tb/tb_mux_arb_nway.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/mux_arb_nway_if.sv
// N-way channel bundle for mux_arb_nway: producer words/handshakes on one side, registered output on the other.
// The mux takes the master modport (it drives in_ready and the output word); the environment takes slave.
interface mux_arb_nway_if #(
  parameter int WIDTH = 16,
  parameter int WAYS  = 8
);
  localparam int SELW = $clog2(WAYS);

  logic [WAYS*WIDTH-1:0] in_data;
  logic [WAYS-1:0]       in_valid;
  logic [WAYS-1:0]       in_ready;
  logic                  mode;
  logic [SELW-1:0]       sel;
  logic [WIDTH-1:0]      out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [SELW-1:0]       out_sel;

  modport master (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_valid, out_sel
  );

  modport slave (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_valid, out_sel
  );
endinterface

// File: rtl/mux_arb_nway.sv
// Registered N-way mux: round-robin or forced-select grant into a one-entry output register.
// Latency 1 cycle; in_ready is all zero while the output word is held (out_valid=1, out_ready=0).
module mux_arb_nway #(
  parameter int WIDTH = 16,
  parameter int WAYS  = 8
) (
  input  logic                clk,
  input  logic                reset,
  mux_arb_nway_if.master      bus
);
  localparam int SELW = $clog2(WAYS);
  localparam int PADW = 1 << SELW;

  logic [SELW-1:0]  ptr;
  logic [SELW-1:0]  rr_gnt;
  logic             rr_vld;
  logic             fs_vld;
  logic [SELW-1:0]  gnt;
  logic             gnt_vld;
  logic             load;
  logic [PADW-1:0]  valid_pad;
  logic [PADW-1:0]  rdy_pad;
  logic [31:0]      sel_ext;
  logic [WIDTH-1:0] words [PADW];

  logic [WIDTH-1:0] data_q;
  logic [SELW-1:0]  sel_q;
  logic             valid_q;

  // Pad to a power of two so every select code indexes a real slot; unused slots read as idle.
  for (genvar i = 0; i < PADW; i++) begin : g_unpack
    if (i < WAYS) begin : g_real
      assign words[i] = bus.in_data[i*WIDTH +: WIDTH];
    end else begin : g_pad
      assign words[i] = '0;
    end
  end

  assign valid_pad = PADW'(bus.in_valid);
  assign sel_ext   = 32'(bus.sel);
  assign fs_vld    = (sel_ext < 32'(WAYS)) && valid_pad[bus.sel];

  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    int idx;
    idx    = 0;
    rr_vld = 1'b0;
    rr_gnt = '0;
    for (int k = WAYS - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= WAYS) idx = idx - WAYS;
      if (valid_pad[idx[SELW-1:0]]) begin
        rr_vld = 1'b1;
        rr_gnt = idx[SELW-1:0];
      end
    end
  end

  assign gnt     = bus.mode ? bus.sel : rr_gnt;
  assign gnt_vld = bus.mode ? fs_vld  : rr_vld;
  assign load    = ~valid_q | bus.out_ready;

  always_comb begin
    rdy_pad = '0;
    if (load && gnt_vld && !reset) rdy_pad[gnt] = 1'b1;
  end

  assign bus.in_ready = rdy_pad[WAYS-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      ptr     <= '0;
    end else if (load) begin
      if (gnt_vld) begin
        data_q  <= words[gnt];
        sel_q   <= gnt;
        valid_q <= 1'b1;
        if (!bus.mode) ptr <= (32'(gnt) == 32'(WAYS - 1)) ? '0 : gnt + SELW'(1);
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_sel   = sel_q;
  assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_mux_arb_nway.sv
// Directed bench for mux_arb_nway (WAYS=8, WIDTH=16) with hand-computed expectations.
module tb_mux_arb_nway;
  localparam int WIDTH = 16;
  localparam int WAYS  = 8;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  logic [WIDTH-1:0] data [WAYS];

  mux_arb_nway_if #(.WIDTH(WIDTH), .WAYS(WAYS)) bus ();

  mux_arb_nway #(.WIDTH(WIDTH), .WAYS(WAYS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always_comb begin
    bus.in_data = '0;
    for (int i = 0; i < WAYS; i++) bus.in_data[i*WIDTH +: WIDTH] = data[i];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp_rdy;
    int         exp_seq [3];

    for (int i = 0; i < WAYS; i++) data[i] = WIDTH'(16'h1111 * (i + 1));
    bus.in_valid  = '0;
    bus.mode      = 1'b0;
    bus.sel       = '0;
    bus.out_ready = 1'b0;

    // reset state
    #1 reset = 1'b1;
    #2;
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_out_data",  32'(bus.out_data),  32'd0);
    check_eq("rst_out_sel",   32'(bus.out_sel),   32'd0);
    bus.in_valid  = 8'hFF;
    bus.out_ready = 1'b1;
    #1;
    check_eq("rst_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    reset        = 1'b0;
    bus.in_valid = 8'h00;
    tick();
    check_eq("idle_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("idle_out_data",  32'(bus.out_data),  32'd0);
    check_eq("idle_in_ready",  32'(bus.in_ready),  32'd0);

    // forced-select sweep
    bus.mode     = 1'b1;
    bus.in_valid = 8'hFF;
    for (int s = 0; s < WAYS; s++) begin
      bus.sel = 3'(s);
      #1;
      exp_rdy = 8'd1 << s;
      check_eq("fs_in_ready", 32'(bus.in_ready), 32'(exp_rdy));
      tick();
      check_eq("fs_out_data",  32'(bus.out_data),  32'(16'h1111 * (s + 1)));
      check_eq("fs_out_sel",   32'(bus.out_sel),   32'(s));
      check_eq("fs_out_valid", 32'(bus.out_valid), 32'd1);
    end

    // round-robin fairness, ptr still 0 after forced transfers
    bus.mode = 1'b0;
    for (int k = 0; k < 16; k++) begin
      #1;
      exp_rdy = 8'd1 << (k % 8);
      check_eq("rr_in_ready", 32'(bus.in_ready), 32'(exp_rdy));
      tick();
      check_eq("rr_out_sel",  32'(bus.out_sel),  32'(k % 8));
      check_eq("rr_out_data", 32'(bus.out_data), 32'(16'h1111 * ((k % 8) + 1)));
    end

    // sparse requests: park ptr at 3, then 7 -> 2 -> 7
    bus.in_valid = 8'h04;
    tick();
    check_eq("sp_prime_sel", 32'(bus.out_sel), 32'd2);
    bus.in_valid = 8'h84;
    exp_seq = '{7, 2, 7};
    for (int k = 0; k < 3; k++) begin
      #1;
      exp_rdy = 8'd1 << exp_seq[k];
      check_eq("sp_in_ready", 32'(bus.in_ready), 32'(exp_rdy));
      tick();
      check_eq("sp_out_sel", 32'(bus.out_sel), 32'(exp_seq[k]));
    end

    // backpressure
    bus.mode     = 1'b1;
    bus.sel      = 3'd0;
    data[0]      = 16'hABCD;
    bus.in_valid = 8'h01;
    tick();
    check_eq("bp_first_data", 32'(bus.out_data), 32'h0000_ABCD);
    bus.out_ready = 1'b0;
    data[0]       = 16'h1234;
    for (int k = 0; k < 5; k++) begin
      #1;
      check_eq("bp_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
      check_eq("bp_hold_data",  32'(bus.out_data),  32'h0000_ABCD);
      check_eq("bp_hold_valid", 32'(bus.out_valid), 32'd1);
    end
    bus.out_ready = 1'b1;
    #1;
    check_eq("bp_release_rdy", 32'(bus.in_ready), 32'h01);
    tick();
    check_eq("bp_next_data",  32'(bus.out_data),  32'h0000_1234);
    check_eq("bp_next_valid", 32'(bus.out_valid), 32'd1);

    // forced select of an idle channel drains the held word
    bus.sel      = 3'd5;
    bus.in_valid = 8'hDF;
    #1;
    check_eq("idle_fs_rdy", 32'(bus.in_ready), 32'd0);
    tick();
    check_eq("idle_fs_valid", 32'(bus.out_valid), 32'd0);
    check_eq("idle_fs_data",  32'(bus.out_data),  32'h0000_1234);
    check_eq("idle_fs_sel",   32'(bus.out_sel),   32'd0);

    // async reset mid-stream with ptr moved off 0
    bus.mode     = 1'b0;
    bus.in_valid = 8'hFF;
    tick();
    tick();
    check_eq("ar_pre_sel", 32'(bus.out_sel), 32'd1);
    #2 reset = 1'b1;
    #1;
    check_eq("ar_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("ar_out_data",  32'(bus.out_data),  32'd0);
    check_eq("ar_out_sel",   32'(bus.out_sel),   32'd0);
    check_eq("ar_in_ready",  32'(bus.in_ready),  32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("ar_restart_rdy", 32'(bus.in_ready), 32'h01);
    tick();
    check_eq("ar_restart_sel",  32'(bus.out_sel),  32'd0);
    check_eq("ar_restart_data", 32'(bus.out_data), 32'h0000_1234);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
